// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - dcache line-refill/write-back memory responder with programmable latency
module dmem_responder #(
    parameter int LATENCY    = 5,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [27:0]  mem_addr,
    input  logic [127:0] mem_wdata,
    output logic         mem_ready,
    output logic [127:0] mem_rdata,
    output logic         err_both
);

    localparam int         DEPTH  = 1 << DEPTH_LOG2;
    localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t               state;
    logic [7:0]           count;
    logic [127:0]         store [DEPTH];
    logic [DEPTH_LOG2-1:0] idx;
    logic                 req;
    logic                 commit_now;
    logic                 unused_addr;

    assign idx         = mem_addr[DEPTH_LOG2-1:0];
    assign req         = mem_read | mem_write;
    assign unused_addr = ^mem_addr[27:DEPTH_LOG2];

    // Commit happens on the last cycle before RESP; with LATENCY==1 that is the accepting IDLE cycle.
    always_comb begin
        commit_now = 1'b0;
        if (req) begin
            if (state == IDLE && LATENCY == 1) begin
                commit_now = 1'b1;
            end else if (state == BUSY && count == 8'd1) begin
                commit_now = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            count     <= 8'd0;
            mem_ready <= 1'b0;
            mem_rdata <= '0;
            err_both  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                store[i] <= '0;
            end
        end else begin
            mem_ready <= 1'b0;
            err_both  <= 1'b0;

            // Write wins when both request lines are high at commit.
            if (commit_now) begin
                if (mem_write) begin
                    store[idx] <= mem_wdata;
                end else begin
                    mem_rdata <= store[idx];
                end
                err_both  <= mem_read & mem_write;
                mem_ready <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (req) begin
                        if (LATENCY == 1) begin
                            state <= RESP;
                        end else begin
                            state <= BUSY;
                            count <= LAT_M1;
                        end
                    end
                end
                BUSY: begin
                    if (!req) begin
                        state <= IDLE;
                        count <= 8'd0;
                    end else if (count == 8'd1) begin
                        state <= RESP;
                        count <= 8'd0;
                    end else begin
                        count <= count - 8'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    count <= 8'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - table, directed and randomized checks of dmem_responder against a line-store model
module tb_dmem_responder;

    localparam int L     = 5;
    localparam int DL    = 8;
    localparam int DEPTH = 1 << DL;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         mem_read = 1'b0;
    logic         mem_write = 1'b0;
    logic [27:0]  mem_addr = '0;
    logic [127:0] mem_wdata = '0;
    logic         mem_ready;
    logic [127:0] mem_rdata;
    logic         err_both;

    always #5 clk = ~clk;

    dmem_responder #(.LATENCY(L), .DEPTH_LOG2(DL)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .err_both  (err_both)
    );

    logic [127:0] model [DEPTH];
    logic [127:0] last_rd;
    bit           in_resp;
    int           total = 0;
    int           bad = 0;

    typedef struct {
        logic         rd;
        logic         wr;
        logic [27:0]  addr;
        logic [127:0] wdata;
        int           gap;
        logic [127:0] exp_rdata;
        logic         exp_err;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        last_rd = '0;
    endtask

    task automatic rest(input int n);
        mem_read  = 1'b0;
        mem_write = 1'b0;
        for (int i = 0; i < n; i++) begin
            cyc();
            if (i == 0 && in_resp) begin
                chk("ready_single_pulse", mem_ready, 1'b0);
                chk("err_single_pulse", err_both, 1'b0);
            end
        end
        in_resp = 0;
    endtask

    // Request uses (a0,d0) in its first cycle and (a1,d1) afterwards; only the latter may commit.
    task automatic op(input logic rd, input logic wr, input logic [27:0] a0, input logic [127:0] d0,
                      input logic [27:0] a1, input logic [127:0] d1, input int gap);
        int exp_lat;
        int lat;
        if (gap > 0) rest(gap);
        exp_lat   = in_resp ? L + 1 : L;
        mem_read  = rd;
        mem_write = wr;
        mem_addr  = a0;
        mem_wdata = d0;
        lat = -1;
        for (int n = 1; n <= exp_lat + 3; n++) begin
            cyc();
            if (n == 1) begin
                mem_addr  = a1;
                mem_wdata = d1;
            end
            if (mem_ready) begin
                lat = n;
                break;
            end
        end
        if (wr) model[a1 % DEPTH] = d1;
        else if (rd) last_rd = model[a1 % DEPTH];
        chk("latency", 128'(lat), 128'(exp_lat));
        chk("rdata", mem_rdata, last_rd);
        chk("err_both", err_both, rd & wr);
        in_resp = 1;
    endtask

    task automatic drop_op(input logic rd, input logic wr, input logic [27:0] a, input logic [127:0] d,
                           input int k);
        int seen;
        seen = 0;
        if (in_resp) rest(1);
        mem_read  = rd;
        mem_write = wr;
        mem_addr  = a;
        mem_wdata = d;
        for (int n = 0; n < k; n++) begin
            cyc();
            if (mem_ready) seen++;
        end
        mem_read  = 1'b0;
        mem_write = 1'b0;
        for (int n = 0; n < L + 2; n++) begin
            cyc();
            if (mem_ready) seen++;
        end
        chk("drop_no_ready", 128'(seen), 128'd0);
        in_resp = 0;
    endtask

    task automatic reset_mid();
        int seen;
        seen = 0;
        rest(1);
        mem_read = 1'b1;
        mem_addr = 28'h12;
        cyc();
        cyc();
        rst      = 1'b1;
        mem_read = 1'b0;
        cyc();
        chk("rst_rdata", mem_rdata, 128'd0);
        chk("rst_ready", mem_ready, 1'b0);
        rst = 1'b0;
        model_clear();
        for (int n = 0; n < L + 2; n++) begin
            cyc();
            if (mem_ready) seen++;
        end
        chk("rst_no_ready", 128'(seen), 128'd0);
        in_resp = 0;
    endtask

    localparam logic [127:0] P_A5 = 128'hA5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5;
    localparam logic [127:0] P_B  = 128'h5555_0005_AAAA_0005_1234_5678_9ABC_DEF0;
    localparam logic [127:0] P_D  = 128'hDEAD_BEEF_0100_0000_1111_2222_3333_4444;
    localparam logic [127:0] P_E  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] P_W  = 128'hC0FF_EE00_3030_3030_0BAD_F00D_7777_8888;
    localparam logic [127:0] P_X  = 128'h4040_4040_4040_4040_4040_4040_4040_4040;
    localparam logic [127:0] P_Y  = 128'h4141_4141_4141_4141_4141_4141_4141_4141;

    initial begin
        logic [27:0]  a0, a1;
        logic [127:0] d0, d1;
        logic         rd, wr;
        int           kind;

        model_clear();
        in_resp = 0;

        tbl[0] = '{1'b1, 1'b0, 28'h0000003, 128'd0, 1, 128'd0, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 28'h0000012, P_A5,   1, 128'd0, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 28'h0000012, 128'd0, 0, P_A5,   1'b0};
        tbl[3] = '{1'b1, 1'b1, 28'h0000005, P_B,    1, P_A5,   1'b1};
        tbl[4] = '{1'b1, 1'b0, 28'h0000005, 128'd0, 0, P_B,    1'b0};
        tbl[5] = '{1'b0, 1'b1, 28'h0000100, P_D,    2, P_B,    1'b0};
        tbl[6] = '{1'b1, 1'b0, 28'h0000000, 128'd0, 0, P_D,    1'b0};
        tbl[7] = '{1'b1, 1'b0, 28'h0000200, 128'd0, 1, P_D,    1'b0};
        tbl[8] = '{1'b0, 1'b1, 28'hFFFFFFF, P_E,    0, P_D,    1'b0};
        tbl[9] = '{1'b1, 1'b0, 28'h00000FF, 128'd0, 0, P_E,    1'b0};

        cyc();
        cyc();
        cyc();
        chk("reset_ready", mem_ready, 1'b0);
        chk("reset_rdata", mem_rdata, 128'd0);
        chk("reset_err", err_both, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            op(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].addr, tbl[i].wdata, tbl[i].gap);
            chk("tbl_rdata", mem_rdata, tbl[i].exp_rdata);
            chk("tbl_err", err_both, tbl[i].exp_err);
        end

        // Write-back then fetch: write drops and read rises in the RESP cycle.
        op(1'b0, 1'b1, 28'h30, P_W, 28'h30, P_W, 1);
        op(1'b1, 1'b0, 28'h30, 128'd0, 28'h30, 128'd0, 0);
        chk("wb_fetch_rdata", mem_rdata, P_W);

        drop_op(1'b0, 1'b1, 28'h12, P_X, 2);
        op(1'b1, 1'b0, 28'h12, 128'd0, 28'h12, 128'd0, 1);
        chk("drop_old_data", mem_rdata, P_A5);

        reset_mid();
        op(1'b1, 1'b0, 28'h12, 128'd0, 28'h12, 128'd0, 1);
        chk("post_reset_store", mem_rdata, 128'd0);

        // Address/data settle one cycle after the request rises.
        op(1'b0, 1'b1, 28'h40, P_X, 28'h41, P_Y, 1);
        op(1'b1, 1'b0, 28'h41, 128'd0, 28'h41, 128'd0, 0);
        chk("settle_new_addr", mem_rdata, P_Y);
        op(1'b1, 1'b0, 28'h40, 128'd0, 28'h40, 128'd0, 1);
        chk("settle_old_addr", mem_rdata, 128'd0);

        for (int i = 0; i < 150; i++) begin
            kind = $urandom_range(0, 9);
            rd   = (kind <= 4);
            wr   = (kind == 0) || (kind >= 5);
            a0   = 28'($urandom);
            if ($urandom_range(0, 1) == 1) a0[7:0] = 8'($urandom_range(0, 7));
            d0   = {$urandom, $urandom, $urandom, $urandom};
            a1   = a0;
            d1   = d0;
            if ($urandom_range(0, 3) == 0) begin
                a1 = 28'($urandom);
                d1 = {$urandom, $urandom, $urandom, $urandom};
            end
            if ($urandom_range(0, 99) < 15) begin
                drop_op(rd, wr, a0, d0, $urandom_range(1, L - 1));
            end else begin
                op(rd, wr, a0, d0, a1, d1, $urandom_range(0, 2));
            end
        end

        rest(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
